// File: rtl/bcd_conv_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM state encoding and
// operand/BCD constants used by the top level and the testbench model.
package bcd_conv_arb_pkg;

    // Operand width of every requester and of the shared converter.
    localparam int OPERAND_W = 16;

    // Largest binary value that fits in four BCD digits.
    localparam logic [OPERAND_W-1:0] BCD_MAX = 16'd9999;

    // Saturated BCD result reported for out-of-range operands.
    localparam logic [OPERAND_W-1:0] BCD_SAT = 16'h9999;

    // One-hot controller states.
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        SETUP = 6'b000010,
        START = 6'b000100,
        WAIT  = 6'b001000,
        CAPT  = 6'b010000,
        RESP  = 6'b100000
    } state_e;

endpackage

// File: rtl/bcd_conv_arb_rr_pick.sv
// rr_pick: combinational round-robin winner selection.
// Searches upward from last_grant+1 (wrapping modulo N_REQ) and returns the
// first active requester; any_req flags that at least one request is present.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant,
    output logic             any_req
);

    // Rotating priority search starting just above the previous winner.
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                grant = idx[IDX_W-1:0];
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin arbiter that shares one binary-to-BCD converter
// among N_REQ requesters. Operands above 9999 bypass the converter and are
// answered with a saturated result and rsp_err.
// Optional feature: define BCD_ARB_TIMEOUT_EN to add a watchdog in WAIT that
// aborts a conversion after TIMEOUT_CYC cycles without conv_done.
module bcd_conv_arb
    import bcd_conv_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*16-1:0]    req_data,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [15:0]            rsp_bcd,
    output logic                   rsp_err,
    output logic                   conv_en,
    output logic [15:0]            conv_data,
    input  logic                   conv_done,
    input  logic [15:0]            conv_bcd,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e                 state_reg;
    state_e                 state_next;
    logic [IDX_W-1:0]       winner_reg;
    logic [IDX_W-1:0]       last_grant_reg;
    logic [OPERAND_W-1:0]   conv_data_reg;
    logic [OPERAND_W-1:0]   rsp_bcd_reg;
    logic                   rsp_err_reg;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_req;
    logic                   timeout;
    logic [OPERAND_W-1:0]   operand_arr [N_REQ];

    // Unpack the flat operand bus into one word per requester.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_operand
        assign operand_arr[gi] = req_data[16*gi +: 16];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (grant_idx),
        .any_req    (any_req)
    );

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt_reg;

    // The conversion is abandoned on the last allowed WAIT cycle unless
    // conv_done shows up in that same cycle.
    assign timeout = (state_reg == WAIT) && !conv_done &&
                     (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT cycles and is cleared in every other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end else begin
            wd_cnt_reg <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the state-decoded strobes.
    always_comb begin
        state_next = state_reg;
        conv_en    = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                // Out-of-range operands never reach the converter.
                if (conv_data_reg > BCD_MAX) begin
                    state_next = RESP;
                end else begin
                    state_next = START;
                end
            end
            START: begin
                conv_en    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    state_next = CAPT;
                end else if (timeout) begin
                    state_next = RESP;
                end
            end
            CAPT: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Transaction datapath: latch winner/operand, capture result, rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_reg     <= '0;
            last_grant_reg <= IDX_W'(N_REQ - 1);
            conv_data_reg  <= '0;
            rsp_bcd_reg    <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        winner_reg    <= grant_idx;
                        conv_data_reg <= operand_arr[grant_idx];
                    end
                end
                SETUP: begin
                    if (conv_data_reg > BCD_MAX) begin
                        rsp_bcd_reg <= BCD_SAT;
                        rsp_err_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!conv_done && timeout) begin
                        rsp_bcd_reg <= '0;
                        rsp_err_reg <= 1'b1;
                    end
                end
                CAPT: begin
                    rsp_bcd_reg <= conv_bcd;
                    rsp_err_reg <= 1'b0;
                end
                RESP: begin
                    last_grant_reg <= winner_reg;
                    rsp_err_reg    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // One-hot response strobe to the winning requester only.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = (state_reg == RESP) && (winner_reg == IDX_W'(gi));
    end

    assign rsp_bcd   = rsp_bcd_reg;
    assign rsp_err   = rsp_err_reg;
    assign conv_data = conv_data_reg;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Self-checking bench for bcd_conv_arb with a behavioural converter model.
// Build with BCD_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_bcd_conv_arb;

    localparam int N_REQ    = 4;
    localparam int TB_TO    = 40;
    localparam int CONV_LAT = 19;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*16-1:0]  req_data;
    logic [N_REQ-1:0]     rsp_valid;
    logic [15:0]          rsp_bcd;
    logic                 rsp_err;
    logic                 conv_en;
    logic [15:0]          conv_data;
    logic                 conv_done;
    logic [15:0]          conv_bcd;
    logic                 busy;

    bcd_conv_arb #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_bcd   (rsp_bcd),
        .rsp_err   (rsp_err),
        .conv_en   (conv_en),
        .conv_data (conv_data),
        .conv_done (conv_done),
        .conv_bcd  (conv_bcd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- converter model ----------------
    logic        active;
    int          cnt;
    logic [15:0] cv_op;
    logic        conv_never;
    logic        force_done;
    logic        conv_done_model;

    function automatic logic [15:0] to_bcd(input logic [15:0] v);
        int x;
        x = int'(v);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Converter: counts CONV_LAT cycles after conv_en, result valid after conv_done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= 0;
            cv_op    <= '0;
            conv_bcd <= '0;
        end else if (conv_en) begin
            active <= 1'b1;
            cnt    <= 1;
            cv_op  <= conv_data;
        end else if (active) begin
            if (conv_done_model) begin
                active   <= 1'b0;
                conv_bcd <= to_bcd(cv_op);
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    assign conv_done_model = active && !conv_never && (cnt == CONV_LAT);
    assign conv_done       = conv_done_model | force_done;

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int          ch;
        logic [15:0] bcd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   conv_en_cycles = 0;
    logic [15:0] prev_cd;
    logic prev_busy;
    logic prev_rst;

    // Compare every response against the queue; watch conv_data stability.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                $display("rsp: valid=%b bcd=%h err=%b (expected ch%0d bcd=%h err=%b)",
                         rsp_valid, rsp_bcd, rsp_err, e.ch, e.bcd, e.err);
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.ch));
                chk("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (conv_en) begin
            conv_en_cycles <= conv_en_cycles + 1;
        end
        if (rst_n && prev_rst && (conv_data !== prev_cd)) begin
            chk("conv_data_change_only_in_setup", {30'd0, prev_busy, busy}, 32'b01);
        end
        prev_cd   <= conv_data;
        prev_busy <= busy;
        prev_rst  <= rst_n;
    end

    // ---------------- helpers ----------------
    task automatic push_exp(input int ch, input logic [15:0] bcd, input logic err);
        exp_t x;
        x.ch  = ch;
        x.bcd = bcd;
        x.err = err;
        sb.push_back(x);
    endtask

    // Latency counts the calling cycle as 1, plus one per following cycle.
    task automatic wait_rsp(input int ch, output int lat);
        lat = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[ch]) return;
        end
        chk("rsp_wait_timeout", 32'd1, 32'd0);
        lat = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_conv_en"},   32'(conv_en),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_rsp_bcd"},   32'(rsp_bcd),   32'd0);
        chk({tag, "_conv_data"}, 32'(conv_data), 32'd0);
    endtask

    // Single-requester transaction driven in IDLE; response checked by monitor.
    task automatic do_txn(input int ch, input logic [15:0] data,
                          input logic [15:0] bcd, input logic err);
        int lat;
        int en0;
        req_data[16*ch +: 16] = data;
        req[ch] = 1'b1;
        push_exp(ch, bcd, err);
        en0 = conv_en_cycles;
        wait_rsp(ch, lat);
        req[ch] = 1'b0;
        chk("latency", 32'(lat), err ? 32'd3 : 32'(5 + CONV_LAT));
        chk("conv_en_cycles", 32'(conv_en_cycles - en0), err ? 32'd0 : 32'd1);
        @(negedge clk);
    endtask

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [15:0] bcd;
        logic        err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        int n;
        int cyc;
        int last_cyc;

        vecs[0] = '{0, 16'd1234,  16'h1234, 1'b0};
        vecs[1] = '{2, 16'd10000, 16'h9999, 1'b1};
        vecs[2] = '{1, 16'd65535, 16'h9999, 1'b1};
        vecs[3] = '{3, 16'd5678,  16'h5678, 1'b0};
        vecs[4] = '{1, 16'd0,     16'h0000, 1'b0};
        vecs[5] = '{2, 16'd9999,  16'h9999, 1'b0};
        vecs[6] = '{0, 16'd10,    16'h0010, 1'b0};
        vecs[7] = '{3, 16'd10001, 16'h9999, 1'b1};
        vecs[8] = '{1, 16'd4095,  16'h4095, 1'b0};
        vecs[9] = '{2, 16'd807,   16'h0807, 1'b0};

        rst_n      = 1'b0;
        req        = '0;
        req_data   = '0;
        conv_never = 1'b0;
        force_done = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Table-driven single transactions.
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].ch, vecs[i].data, vecs[i].bcd, vecs[i].err);
        end

        // All four requesting at once: served ch0..ch3 (last_grant is ch0's
        // neighbour set by the table? no: priority continues from last winner).
        // Last table winner was ch2, so rotate from ch3; realign with a ch3 txn.
        do_txn(3, 16'd1, 16'h0001, 1'b0);
        req_data = {16'd9999, 16'd10, 16'd9, 16'd0};
        push_exp(0, 16'h0000, 1'b0);
        push_exp(1, 16'h0009, 1'b0);
        push_exp(2, 16'h0010, 1'b0);
        push_exp(3, 16'h9999, 1'b0);
        req = 4'b1111;
        n = 0;
        cyc = 0;
        last_cyc = 0;
        for (int k = 0; k < 400 && n < 4; k++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != '0) begin
                chk("rr_order", 32'(rsp_valid), 32'(1 << n));
                if (n > 0) chk("rsp_spacing", 32'(cyc - last_cyc), 32'(CONV_LAT + 5));
                last_cyc = cyc;
                req = req & ~rsp_valid;
                n++;
            end
        end
        chk("rr_all_served", 32'(n), 32'd4);
        req = '0;
        @(negedge clk);

        // Drop req and change data while busy; stray conv_done in SETUP/START.
        req_data[63:48] = 16'd42;
        req[3] = 1'b1;
        push_exp(3, 16'h0042, 1'b0);
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        req_data[63:48] = 16'd7777;
        @(negedge clk);
        force_done = 1'b0;
        wait_rsp(3, lat);
        chk("late_drop_latency", 32'(lat), 32'(2 + CONV_LAT));
        @(negedge clk);

        // conv_done while idle must not start anything.
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_conv_done_busy", 32'(busy), 32'd0);

        // Reset in WAIT aborts silently.
        req_data[15:0] = 16'd555;
        req[0] = 1'b1;
        repeat (8) @(negedge clk);
        chk("in_wait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        check_reset_outputs("midreset");
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        do_txn(1, 16'd321, 16'h0321, 1'b0);

`ifdef BCD_ARB_TIMEOUT_EN
        // Converter that never answers: watchdog ends the transaction.
        conv_never = 1'b1;
        req_data[15:0] = 16'd500;
        req[0] = 1'b1;
        push_exp(0, 16'h0000, 1'b1);
        wait_rsp(0, lat);
        req[0] = 1'b0;
        chk("timeout_latency", 32'(lat), 32'(4 + TB_TO));
        @(negedge clk);
        conv_never = 1'b0;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_ignored_busy", 32'(busy), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
